// File: rtl/gen_cnt_pkg.sv
// gen_cnt_pkg: mode codes and Gray helper shared by gen_mode_counter.
// Optional prescaler is enabled by the GEN_CNT_PRESCALE_EN macro.
package gen_cnt_pkg;

  localparam int MODE_UP   = 0;
  localparam int MODE_DOWN = 1;
  localparam int MODE_SAT  = 2;
  localparam int MODE_GRAY = 3;

  localparam int GRAY_MAXW = 64;

  // Fixed-width helper; callers zero-extend and slice to their width.
  function automatic logic [GRAY_MAXW-1:0] bin2gray(
    input logic [GRAY_MAXW-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gen_cnt_chan.sv
// gen_cnt_chan: one counter channel; MODE selects the step rule.
// Used by gen_mode_counter, which owns the shared tick.
module gen_cnt_chan
  import gen_cnt_pkg::*;
#(
  parameter int W    = 8,
  parameter int MODE = MODE_UP
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         en,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] TOP = '1;

  logic [W-1:0] r_bin;
  logic         r_tc;
  logic [W-1:0] w_step;
  logic         w_hit;
  logic [W-1:0] w_nxt;
  logic         w_tc_nxt;

  generate
    case (MODE)
      MODE_UP: begin : g_up
        assign w_step = r_bin + ONE;
        assign w_hit  = (r_bin == TOP);
      end
      MODE_DOWN: begin : g_down
        assign w_step = r_bin - ONE;
        assign w_hit  = (r_bin == '0);
      end
      MODE_SAT: begin : g_sat
        assign w_step = (r_bin == TOP) ? r_bin : r_bin + ONE;
        assign w_hit  = (r_bin == TOP - ONE);
      end
      default: begin : g_gray_step
        assign w_step = r_bin + ONE;
        assign w_hit  = (r_bin == TOP);
      end
    endcase
  endgenerate

  always_comb begin
    w_nxt    = r_bin;
    w_tc_nxt = 1'b0;
    if (ld) begin
      w_nxt = ld_val;
    end else if (en && tick) begin
      w_nxt    = w_step;
      w_tc_nxt = w_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin <= '0;
      r_tc  <= 1'b0;
    end else begin
      r_bin <= w_nxt;
      r_tc  <= w_tc_nxt;
    end
  end

  assign tc = r_tc;

  generate
    if (MODE == MODE_UP || MODE == MODE_DOWN ||
        MODE == MODE_SAT) begin : g_bin_out
      assign cnt = r_bin;
    end else begin : g_gray_out
      // Gray code is registered from the next binary state.
      logic [GRAY_MAXW-1:0] w_g;
      logic [W-1:0]         r_gray;
      logic                 w_unused_g;

      assign w_g        = bin2gray(GRAY_MAXW'(w_nxt));
      assign w_unused_g = ^w_g;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_gray <= '0;
        end else begin
          r_gray <= w_g[W-1:0];
        end
      end

      assign cnt = r_gray;
    end
  endgenerate

endmodule

// File: rtl/gen_mode_counter.sv
// gen_mode_counter: CH independent W-bit counters sharing one tick.
// Define GEN_CNT_PRESCALE_EN to divide the tick by PRESCALE.
module gen_mode_counter
  import gen_cnt_pkg::*;
#(
  parameter int CH       = 4,
  parameter int W        = 8,
  parameter int MODE     = 0,
  parameter int PRESCALE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   en,
  input  logic [CH-1:0]   ld,
  input  logic [CH*W-1:0] ld_val,
  output logic [CH*W-1:0] cnt,
  output logic [CH-1:0]   tc
);

  logic w_tick;

  generate
    if (CH < 1 || W < 2 || W > GRAY_MAXW ||
        PRESCALE < 1) begin : g_bad_param
      $error("gen_mode_counter: illegal CH/W/PRESCALE");
    end
  endgenerate

`ifdef GEN_CNT_PRESCALE_EN
  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] P_ONE  = PW'(1);

  logic [PW-1:0] r_pre;

  // Free-running; en/ld never stall it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
    end else if (r_pre == P_LAST) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + P_ONE;
    end
  end

  assign w_tick = (r_pre == P_LAST);
`else
  assign w_tick = 1'b1;
`endif

  generate
    for (genvar i = 0; i < CH; i++) begin : g_ch
      gen_cnt_chan #(
        .W    (W),
        .MODE (MODE)
      ) u_chan (
        .clk    (clk),
        .rst    (rst),
        .tick   (w_tick),
        .en     (en[i]),
        .ld     (ld[i]),
        .ld_val (ld_val[i*W +: W]),
        .cnt    (cnt[i*W +: W]),
        .tc     (tc[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_gen_mode_counter.sv
// tb_gen_mode_counter: one DUT per counting mode, checked every cycle
// against an integer reference model; works with or without prescaler.
module tb_gen_mode_counter;

  localparam int NM = 4;
  localparam int CH = 2;
  localparam int W  = 4;
  localparam int PS = 3;
  localparam int MAXV = (1 << W) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   en_a  [NM];
  logic [CH-1:0]   ld_a  [NM];
  logic [CH*W-1:0] ldv_a [NM];
  logic [CH*W-1:0] cnt_a [NM];
  logic [CH-1:0]   tc_a  [NM];

  int n_chk  = 0;
  int n_pass = 0;

  int mb    [NM][CH];
  int mt    [NM][CH];
  int mstep [NM][CH];
  int mp;
  int prev_g [CH];
  int gray_tab [16] = '{0, 1, 3, 2, 6, 7, 5, 4,
                        12, 13, 15, 14, 10, 11, 9, 8};

  always #5 clk = ~clk;

  for (genvar m = 0; m < NM; m++) begin : g_dut
    gen_mode_counter #(
      .CH       (CH),
      .W        (W),
      .MODE     (m),
      .PRESCALE (PS)
    ) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en_a[m]),
      .ld     (ld_a[m]),
      .ld_val (ldv_a[m]),
      .cnt    (cnt_a[m]),
      .tc     (tc_a[m])
    );
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Reference: counters as plain integers, one update per rising edge.
  task automatic model_edge();
    int tick;
`ifdef GEN_CNT_PRESCALE_EN
    tick = (mp == PS - 1) ? 1 : 0;
`else
    tick = 1;
`endif
    if (rst) begin
      mp = 0;
      for (int m = 0; m < NM; m++)
        for (int c = 0; c < CH; c++) begin
          mb[m][c] = 0; mt[m][c] = 0; mstep[m][c] = 0;
        end
      return;
    end
    mp = (mp + 1) % PS;
    for (int m = 0; m < NM; m++)
      for (int c = 0; c < CH; c++) begin
        int b;
        b = mb[m][c];
        mt[m][c] = 0;
        mstep[m][c] = 0;
        if (ld_a[m][c]) begin
          b = int'(ldv_a[m][c*W +: W]);
        end else if (en_a[m][c] && tick == 1) begin
          mstep[m][c] = 1;
          case (m)
            1: begin
              mt[m][c] = (b == 0) ? 1 : 0;
              b = (b + MAXV) % (MAXV + 1);
            end
            2: if (b < MAXV) begin
              b = b + 1;
              mt[m][c] = (b == MAXV) ? 1 : 0;
            end
            default: begin
              mt[m][c] = (b == MAXV) ? 1 : 0;
              b = (b + 1) % (MAXV + 1);
            end
          endcase
        end
        mb[m][c] = b;
      end
  endtask

  task automatic compare();
    for (int m = 0; m < NM; m++)
      for (int c = 0; c < CH; c++) begin
        int got, exp;
        got = int'(cnt_a[m][c*W +: W]);
        exp = (m == 3) ? (mb[m][c] ^ (mb[m][c] >> 1)) : mb[m][c];
        check($sformatf("cnt m%0d c%0d", m, c), got, exp);
        check($sformatf("tc m%0d c%0d", m, c),
              int'(tc_a[m][c]), mt[m][c]);
        if (m == 3) begin
          if (mstep[m][c] == 1) begin
            check("gray_tab", got, gray_tab[mb[m][c]]);
            check("gray_ham", $countones(got ^ prev_g[c]), 1);
          end
          prev_g[c] = got;
        end
      end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic set_all(input logic [CH-1:0] e, input logic [CH-1:0] l,
                         input logic [W-1:0] v);
    for (int m = 0; m < NM; m++) begin
      en_a[m]  = e;
      ld_a[m]  = l;
      ldv_a[m] = {v, v};
    end
  endtask

  initial begin
    mp = 0;
    for (int c = 0; c < CH; c++) prev_g[c] = 0;
    rst = 1'b1;
    set_all(2'b11, 2'b11, 4'h7);
    repeat (2) cyc();
    rst = 1'b0;
    set_all(2'b00, 2'b11, 4'hD);
    cyc();
    set_all(2'b11, 2'b00, 4'h0);
    repeat (60) cyc();
    set_all(2'b11, 2'b11, 4'h5);
    cyc();
    set_all(2'b01, 2'b00, 4'h0);
    repeat (12) cyc();
    set_all(2'b11, 2'b00, 4'h0);
    repeat (5) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set_all(2'b00, 2'b11, 4'h0);
    cyc();
    set_all(2'b11, 2'b00, 4'h0);
    repeat (20) cyc();
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int m = 0; m < NM; m++) begin
        en_a[m]  = 2'($urandom);
        ld_a[m]  = {$urandom_range(0, 7) == 0,
                    $urandom_range(0, 7) == 0};
        ldv_a[m] = 8'($urandom);
      end
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
